// File: rtl/game_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_ctrl_if
//   Bundles the player/timer inputs and the game-status outputs of game_ctrl.
//
//   Signals
//     guess_b    player button (level, synchronous to clk)
//     cmp_r      comparator result, 1 = guess correct
//     time_up    one-cycle expiry pulse from the external timer
//     state      0 WELCOME, 1 READY, 2 PLAY, 3 LOST
//     level      current level
//     lives      remaining lives
//     best       highest level reached since reset
//     time_v     time limit for the current round
//     time_load  one-cycle pulse that loads/starts the external timer
//     g_enable   random-number generator run enable
//
//   Modports
//     master  the game controller (drives status, receives inputs)
//     slave   the environment (drives inputs, receives status)
// -----------------------------------------------------------------------------
interface game_ctrl_if #(
    parameter int LEVEL_W = 8,
    parameter int TIME_W  = 5
);
    logic               guess_b;
    logic               cmp_r;
    logic               time_up;
    logic [1:0]         state;
    logic [LEVEL_W-1:0] level;
    logic [2:0]         lives;
    logic [LEVEL_W-1:0] best;
    logic [TIME_W-1:0]  time_v;
    logic               time_load;
    logic               g_enable;

    modport master (
        input  guess_b, cmp_r, time_up,
        output state, level, lives, best, time_v, time_load, g_enable
    );

    modport slave (
        output guess_b, cmp_r, time_up,
        input  state, level, lives, best, time_v, time_load, g_enable
    );
endinterface

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
//   Control FSM for a guessing game: WELCOME -> READY -> PLAY -> (READY|LOST).
//   Each READY->PLAY transition loads the external timer with a limit that
//   shrinks with the level down to a floor. A correct guess advances the
//   level; a wrong guess or a timer expiry costs a life.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   game_ctrl_if.master (button/comparator/timer in, status out)
//
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module game_ctrl #(
    parameter int LEVEL_W = 8,
    parameter int TIME_W  = 5,
    parameter int T_START = 30,
    parameter int T_STEP  = 2,
    parameter int T_MIN   = 3,
    parameter int LIVES   = 3
) (
    input  logic clk,
    input  logic rst,
    game_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_WELCOME = 2'd0,
        S_READY   = 2'd1,
        S_PLAY    = 2'd2,
        S_LOST    = 2'd3
    } state_t;

    // One guard bit beyond LEVEL_W+TIME_W+1 keeps T_START - T_STEP*level
    // representable as a negative number for any level.
    localparam int CALC_W = LEVEL_W + TIME_W + 2;

    localparam logic signed [CALC_W-1:0] T_START_S = CALC_W'(T_START);
    localparam logic signed [CALC_W-1:0] T_STEP_S  = CALC_W'(T_STEP);
    localparam logic signed [CALC_W-1:0] T_MIN_S   = CALC_W'(T_MIN);
    localparam logic [LEVEL_W-1:0]       LEVEL_MAX = '1;
    localparam logic [2:0]               LIVES_INIT = 3'(LIVES);

    // max(T_START - T_STEP*lvl, T_MIN)
    function automatic logic [TIME_W-1:0] time_limit(input logic [LEVEL_W-1:0] lvl);
        logic signed [CALC_W-1:0] lvl_s;
        logic signed [CALC_W-1:0] t;
        lvl_s = signed'({{(CALC_W-LEVEL_W){1'b0}}, lvl});
        t     = T_START_S - (T_STEP_S * lvl_s);
        if (t < T_MIN_S)
            return TIME_W'(T_MIN);
        return TIME_W'(t);
    endfunction

    function automatic logic [LEVEL_W-1:0] level_inc_sat(input logic [LEVEL_W-1:0] lvl);
        if (lvl == LEVEL_MAX)
            return lvl;
        return lvl + 1'b1;
    endfunction

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [2:0]         lives_q, lives_d;
    logic [LEVEL_W-1:0] best_q,  best_d;
    logic [TIME_W-1:0]  time_q,  time_d;
    logic               tload_q, tload_d;
    logic               gen_q,   gen_d;
    logic               btn_prev_q;
    // Cleared by reset and set once the button has been seen low, so a
    // button held through reset release cannot register as a press.
    logic               btn_armed_q;

    logic               press;
    logic [2:0]         lives_dec;

    assign press     = bus.guess_b & ~btn_prev_q & btn_armed_q;
    assign lives_dec = lives_q - 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WELCOME;
            level_q     <= '0;
            lives_q     <= LIVES_INIT;
            best_q      <= '0;
            time_q      <= TIME_W'(T_START);
            tload_q     <= 1'b0;
            gen_q       <= 1'b1;
            btn_prev_q  <= 1'b0;
            btn_armed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            best_q      <= best_d;
            time_q      <= time_d;
            tload_q     <= tload_d;
            gen_q       <= gen_d;
            btn_prev_q  <= bus.guess_b;
            btn_armed_q <= btn_armed_q | ~bus.guess_b;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        time_d  = time_q;
        tload_d = 1'b0;
        gen_d   = gen_q;

        unique case (state_q)
            S_WELCOME, S_LOST: begin
                if (press) begin
                    state_d = S_READY;
                    level_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            S_READY: begin
                if (press) begin
                    state_d = S_PLAY;
                    time_d  = time_limit(level_q);
                    tload_d = 1'b1;
                    gen_d   = 1'b0;
                end
            end
            S_PLAY: begin
                // time_up takes priority over a simultaneous press
                if (bus.time_up || (press && !bus.cmp_r)) begin
                    lives_d = lives_dec;
                    gen_d   = 1'b1;
                    state_d = (lives_dec != 3'd0) ? S_READY : S_LOST;
                end else if (press) begin
                    level_d = level_inc_sat(level_q);
                    gen_d   = 1'b1;
                    state_d = S_READY;
                end
            end
            default: state_d = S_WELCOME;
        endcase

        // Compare against the next level so best moves on the same edge.
        best_d = (level_d > best_q) ? level_d : best_q;
    end

    assign bus.state     = state_q;
    assign bus.level     = level_q;
    assign bus.lives     = lives_q;
    assign bus.best      = best_q;
    assign bus.time_v    = time_q;
    assign bus.time_load = tload_q;
    assign bus.g_enable  = gen_q;

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl
//   Self-checking bench for game_ctrl with default parameters. Each stimulus
//   cycle pushes the expected register state onto a scoreboard; it is popped
//   and compared one edge later.
// -----------------------------------------------------------------------------
module tb_game_ctrl;

    localparam int LEVEL_W = 8;
    localparam int TIME_W  = 5;
    localparam int T_START = 30;
    localparam int T_STEP  = 2;
    localparam int T_MIN   = 3;
    localparam int LIVES   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    game_ctrl_if #(.LEVEL_W(LEVEL_W), .TIME_W(TIME_W)) bus ();

    game_ctrl #(
        .LEVEL_W(LEVEL_W), .TIME_W(TIME_W), .T_START(T_START),
        .T_STEP(T_STEP), .T_MIN(T_MIN), .LIVES(LIVES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int st;
        int lv;
        int li;
        int be;
        int tv;
        int tl;
        int ge;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // reference state
    int  m_st, m_lv, m_li, m_be, m_tv, m_tl, m_ge;
    bit  m_prev, m_armed;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_time(input int lvl);
        int t;
        t = T_START - T_STEP * lvl;
        return (t < T_MIN) ? T_MIN : t;
    endfunction

    task automatic model_reset();
        m_st = 0; m_lv = 0; m_li = LIVES; m_be = 0;
        m_tv = T_START; m_tl = 0; m_ge = 1;
        m_prev = 1'b0; m_armed = 1'b0;
    endtask

    task automatic model_step(input bit g, input bit c, input bit tu);
        bit p;
        p    = g && !m_prev && m_armed;
        m_tl = 0;
        case (m_st)
            0, 3: if (p) begin m_st = 1; m_lv = 0; m_li = LIVES; end
            1: if (p) begin m_st = 2; m_tv = exp_time(m_lv); m_tl = 1; m_ge = 0; end
            2: begin
                if (tu || (p && !c)) begin
                    m_li = m_li - 1; m_ge = 1;
                    m_st = (m_li > 0) ? 1 : 3;
                end else if (p) begin
                    if (m_lv < 255) m_lv = m_lv + 1;
                    m_ge = 1; m_st = 1;
                end
            end
            default: ;
        endcase
        if (m_lv > m_be) m_be = m_lv;
        m_prev = g;
        if (!g) m_armed = 1'b1;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".state"},     int'(bus.state),     e.st);
        chk({tag, ".level"},     int'(bus.level),     e.lv);
        chk({tag, ".lives"},     int'(bus.lives),     e.li);
        chk({tag, ".best"},      int'(bus.best),      e.be);
        chk({tag, ".time_v"},    int'(bus.time_v),    e.tv);
        chk({tag, ".time_load"}, int'(bus.time_load), e.tl);
        chk({tag, ".g_enable"},  int'(bus.g_enable),  e.ge);
    endtask

    // One clock: drive at negedge, push model expectation, compare after posedge.
    task automatic cycle(input string tag, input bit g, input bit c, input bit tu);
        exp_t e;
        @(negedge clk);
        bus.guess_b = g; bus.cmp_r = c; bus.time_up = tu;
        model_step(g, c, tu);
        e = '{m_st, m_lv, m_li, m_be, m_tv, m_tl, m_ge};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check_all(tag, e);
        end
    endtask

    task automatic press(input string tag, input bit c);
        cycle(tag, 1'b1, c, 1'b0);
        cycle({tag, "_rel"}, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        exp_t e;
        e = '{0, 0, LIVES, 0, T_START, 0, 1};
        check_all(tag, e);
    endtask

    initial begin
        bus.guess_b = 1'b0; bus.cmp_r = 1'b0; bus.time_up = 1'b0;
        model_reset();
        #12;
        check_reset_values("rst0");
        @(negedge clk);
        rst = 1'b0;

        // start a game, enter PLAY at level 0
        cycle("idle", 1'b0, 1'b0, 1'b0);
        press("w2r", 1'b0);
        chk("w2r_state", int'(bus.state), 1);
        cycle("r2p", 1'b1, 1'b0, 1'b0);
        chk("r2p_tload", int'(bus.time_load), 1);
        chk("r2p_time", int'(bus.time_v), 30);
        chk("r2p_gen", int'(bus.g_enable), 0);
        cycle("r2p_rel", 1'b0, 1'b0, 1'b0);
        chk("tload_one", int'(bus.time_load), 0);

        // correct guess at level 0, next limit 28
        press("ok1", 1'b1);
        chk("ok1_level", int'(bus.level), 1);
        chk("ok1_best", int'(bus.best), 1);
        press("r2p_l1", 1'b0);
        chk("l1_time", int'(bus.time_v), 28);

        // climb to level 13, then 14 and 16
        while (m_lv < 13) begin
            press("climb_ok", 1'b1);
            press("climb_go", 1'b0);
        end
        chk("l13_time", int'(bus.time_v), 4);
        press("to14_ok", 1'b1);
        press("to14_go", 1'b0);
        chk("l14_time", int'(bus.time_v), 3);
        repeat (2) begin
            press("to16_ok", 1'b1);
            press("to16_go", 1'b0);
        end
        chk("l16_time", int'(bus.time_v), 3);

        // lose all lives: timeout, then two wrong guesses
        cycle("tup", 1'b0, 1'b0, 1'b1);
        chk("tup_lives", int'(bus.lives), 2);
        chk("tup_state", int'(bus.state), 1);
        press("go_a", 1'b0);
        press("wrong1", 1'b0);
        press("go_b", 1'b0);
        press("wrong2", 1'b0);
        chk("lost_state", int'(bus.state), 3);
        chk("lost_lives", int'(bus.lives), 0);
        cycle("lost_tup", 1'b0, 1'b0, 1'b1);
        press("restart", 1'b0);
        chk("restart_level", int'(bus.level), 0);
        chk("restart_lives", int'(bus.lives), 3);
        chk("restart_best", int'(bus.best), 16);

        // time_up ignored in READY; then time_up beats a correct press
        cycle("ready_tup", 1'b0, 1'b0, 1'b1);
        press("go_c", 1'b0);
        cycle("tie", 1'b1, 1'b1, 1'b1);
        chk("tie_lives", int'(bus.lives), 2);
        chk("tie_level", int'(bus.level), 0);
        cycle("tie_rel", 1'b0, 1'b0, 1'b0);

        // held button: one transition only
        for (int i = 0; i < 10; i++) cycle("hold", 1'b1, 1'b1, 1'b0);
        chk("hold_state", int'(bus.state), 2);
        chk("hold_level", int'(bus.level), 0);

        // asynchronous reset mid-PLAY, button held through release
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("arst");
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_tload", int'(bus.time_load), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle("held_rst", 1'b1, 1'b0, 1'b0);
        chk("held_state", int'(bus.state), 0);
        cycle("held_rel", 1'b0, 1'b0, 1'b0);
        press("w2r_b", 1'b0);
        chk("w2r_b_state", int'(bus.state), 1);

        // level saturation
        press("sat_go", 1'b0);
        while (m_lv < 255) begin
            press("sat_ok", 1'b1);
            press("sat_go", 1'b0);
        end
        press("sat_over", 1'b1);
        chk("sat_level", int'(bus.level), 255);
        chk("sat_best", int'(bus.best), 255);
        press("sat_go2", 1'b0);
        chk("sat_time", int'(bus.time_v), 3);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
